// File: rtl/intr_ctrl_pkg.sv
// Shared constants for the interrupt controller: register byte offsets,
// FSM state encoding and default parameter values.
package intr_ctrl_pkg;

  localparam int          NSRC_DEF      = 8;
  localparam logic [31:0] BASE_ADDR_DEF = 32'hFFFF_FF00;

  // Byte offsets inside the 32-byte window; only Daddr[4:2] is decoded.
  localparam logic [4:0] OFF_PEND = 5'h00;
  localparam logic [4:0] OFF_MASK = 5'h04;
  localparam logic [4:0] OFF_EDGE = 5'h08;
  localparam logic [4:0] OFF_STAT = 5'h0C;
  localparam logic [4:0] OFF_EOI  = 5'h10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SERV = 2'd2;

endpackage

// File: rtl/intr_ctrl_if.sv
// CPU-facing signals of the interrupt controller: data-bus slave port plus
// the Intr/Inta/Ivec handshake.
interface intr_ctrl_if;
  logic [31:0] Daddr;
  logic [31:0] Dwrite;
  logic        Wmem;
  logic        Dsel;
  logic [31:0] Dread;
  logic        Intr;
  logic        Inta;
  logic [4:0]  Ivec;

  modport master (
    output Daddr, Dwrite, Wmem, Inta,
    input  Dsel, Dread, Intr, Ivec
  );

  modport slave (
    input  Daddr, Dwrite, Wmem, Inta,
    output Dsel, Dread, Intr, Ivec
  );
endinterface

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the
// lowest set index (index 0 has the highest priority).
module intr_prio_enc #(
  parameter int NSRC = 8
) (
  input  logic [NSRC-1:0] req_i,
  output logic            any_o,
  output logic [4:0]      id_o
);

  always_comb begin
    any_o = |req_i;
    id_o  = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = 5'(i);
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller: synchronises peripheral requests,
// masks and prioritises them, and runs the Intr/Inta/EOI handshake.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int          NSRC      = NSRC_DEF,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic            Clk,
  input  logic            Clr,
  input  logic [NSRC-1:0] Irq,
  intr_ctrl_if.slave      bus
);

  function automatic logic [31:0] zext(input logic [NSRC-1:0] v);
    zext           = '0;
    zext[NSRC-1:0] = v;
  endfunction

  function automatic logic [NSRC-1:0] onehot(input logic [4:0] id);
    for (int i = 0; i < NSRC; i++) onehot[i] = (5'(i) == id);
  endfunction

  logic [NSRC-1:0] s1_q, s2_q, s3_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, edge_q;
  logic [1:0]      state_q, state_d;
  logic            intr_q;
  logic [4:0]      ivec_q, ivec_d;

  logic [NSRC-1:0] pend, act, rise, w1c, inta_clr;
  logic            any;
  logic [4:0]      win;
  logic            wr;
  logic [4:0]      off;
  logic [31:0]     rdata;
  logic [33:0]     unused_bus;

  assign unused_bus = {bus.Daddr[1:0], bus.Dwrite};

  assign bus.Dsel = (bus.Daddr[31:5] == BASE_ADDR[31:5]);
  assign off      = {bus.Daddr[4:2], 2'b00};
  assign wr       = bus.Wmem & bus.Dsel;
  assign w1c      = (wr && off == OFF_PEND) ? bus.Dwrite[NSRC-1:0] : '0;

  // Level sources are seen straight from the synchroniser; only edge bits are stored.
  assign rise = s2_q & ~s3_q;
  assign pend = (pend_q & edge_q) | (s2_q & ~edge_q);
  assign act  = pend & mask_q;

  intr_prio_enc #(.NSRC(NSRC)) u_prio (
    .req_i (act),
    .any_o (any),
    .id_o  (win)
  );

  always_comb begin
    state_d  = state_q;
    ivec_d   = ivec_q;
    inta_clr = '0;
    case (state_q)
      ST_IDLE: if (any) state_d = ST_REQ;
      ST_REQ: begin
        if (bus.Inta && any) begin
          state_d  = ST_SERV;
          ivec_d   = win;
          inta_clr = onehot(win);
        end else if (!any) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERV: if (wr && off == OFF_EOI) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A new edge beats a same-cycle clear, whether from W1C or from Inta.
  assign pend_d = ((pend_q & ~w1c & ~inta_clr) | rise) & edge_q;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      edge_q  <= '0;
      state_q <= ST_IDLE;
      intr_q  <= 1'b0;
      ivec_q  <= '0;
    end else begin
      s1_q    <= Irq;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pend_q  <= pend_d;
      if (wr && off == OFF_MASK) mask_q <= bus.Dwrite[NSRC-1:0];
      if (wr && off == OFF_EDGE) edge_q <= bus.Dwrite[NSRC-1:0];
      state_q <= state_d;
      intr_q  <= (state_d == ST_REQ);
      ivec_q  <= ivec_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.Dsel) begin
      case (off)
        OFF_PEND: rdata = zext(pend);
        OFF_MASK: rdata = zext(mask_q);
        OFF_EDGE: rdata = zext(edge_q);
        OFF_STAT: rdata = {26'b0, (state_q == ST_SERV), ivec_q};
        default:  rdata = '0;
      endcase
    end
  end

  assign bus.Dread = rdata;
  assign bus.Intr  = intr_q;
  assign bus.Ivec  = ivec_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: a per-edge behavioural model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_intr_ctrl;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam logic [31:0] A_PEND = BASE + 32'h00;
  localparam logic [31:0] A_MASK = BASE + 32'h04;
  localparam logic [31:0] A_EDGE = BASE + 32'h08;
  localparam logic [31:0] A_STAT = BASE + 32'h0C;
  localparam logic [31:0] A_EOI  = BASE + 32'h10;
  localparam logic [31:0] A_RSV  = BASE + 32'h14;
  localparam logic [31:0] A_RSV2 = BASE + 32'h18;

  localparam int M_IDLE = 0, M_WAIT_ACK = 1, M_IN_SERVICE = 2;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] irq = 8'h00;
  bit         running = 1'b1;
  int         n_tot = 0;
  int         n_pass = 0;

  intr_ctrl_if bus ();

  intr_ctrl #(.NSRC(8), .BASE_ADDR(BASE)) dut (
    .Clk (clk),
    .Clr (clr),
    .Irq (irq),
    .bus (bus)
  );

  always #10 clk = ~clk;

  // Behavioural model: the requests the controller sees are Irq delayed two edges.
  logic [7:0] samples[$] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] m_mask = 0, m_edge = 0, m_latched = 0;
  logic [4:0] m_vec = 0;
  int         m_state = M_IDLE;

  function automatic logic [7:0] seen_pending();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_edge[i] ? m_latched[i] : samples[1][i];
    return v;
  endfunction

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic hits(input logic [31:0] a);
    return a[31:5] == BASE[31:5];
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    if (!hits(a)) return 32'h0;
    case (a[4:2])
      3'd0: return {24'h0, seen_pending()};
      3'd1: return {24'h0, m_mask};
      3'd2: return {24'h0, m_edge};
      3'd3: return {26'h0, m_state == M_IN_SERVICE, m_vec};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      samples   = '{8'h00, 8'h00, 8'h00};
      m_mask    = 0;
      m_edge    = 0;
      m_latched = 0;
      m_vec     = 0;
      m_state   = M_IDLE;
    end else begin
      logic [7:0] active, newly, cleared;
      logic       wr_hit;
      int         w;
      active  = seen_pending() & m_mask;
      w       = lowest(active);
      newly   = samples[1] & ~samples[2];
      wr_hit  = bus.Wmem && hits(bus.Daddr);
      cleared = (wr_hit && bus.Daddr[4:2] == 3'd0) ? bus.Dwrite[7:0] : 8'h00;
      if (m_state == M_IDLE) begin
        if (w >= 0) m_state = M_WAIT_ACK;
      end else if (m_state == M_WAIT_ACK) begin
        if (bus.Inta && w >= 0) begin
          m_state    = M_IN_SERVICE;
          m_vec      = 5'(w);
          cleared[w] = 1'b1;
        end else if (w < 0) begin
          m_state = M_IDLE;
        end
      end else if (wr_hit && bus.Daddr[4:2] == 3'd4) begin
        m_state = M_IDLE;
      end
      m_latched = ((m_latched & ~cleared) | newly) & m_edge;
      if (wr_hit && bus.Daddr[4:2] == 3'd1) m_mask = bus.Dwrite[7:0];
      if (wr_hit && bus.Daddr[4:2] == 3'd2) m_edge = bus.Dwrite[7:0];
      samples.push_front(irq);
      void'(samples.pop_back());
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (running) begin
      check("model_intr", {31'h0, bus.Intr}, {31'h0, m_state == M_WAIT_ACK});
      check("model_ivec", {27'h0, bus.Ivec}, {27'h0, m_vec});
      check("model_dsel", {31'h0, bus.Dsel}, {31'h0, hits(bus.Daddr)});
      check("model_dread", bus.Dread, exp_read(bus.Daddr));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.Daddr  = a;
    bus.Dwrite = d;
    bus.Wmem   = 1'b1;
    tick();
    bus.Wmem   = 1'b0;
    bus.Daddr  = 32'h0;
    bus.Dwrite = 32'h0;
  endtask

  task automatic ack();
    bus.Inta = 1'b1;
    tick();
    bus.Inta = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.Daddr = a;
    #1;
    check(name, bus.Dread, exp);
    bus.Daddr = 32'h0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    bus.Daddr = 0; bus.Dwrite = 0; bus.Wmem = 0; bus.Inta = 0;
    #1 clr = 1'b1;
    tick(2);
    clr = 1'b0;
    check("reset_intr", {31'h0, bus.Intr}, 32'h0);
    check("reset_ivec", {27'h0, bus.Ivec}, 32'h0);
    rd("reset_pend", A_PEND, 32'h0);
    rd("reset_stat", A_STAT, 32'h0);
    bus.Daddr = 32'h0000_1000;
    #1 check("dsel_miss", {31'h0, bus.Dsel}, 32'h0);
    bus.Daddr = A_RSV;
    #1 check("dsel_hit", {31'h0, bus.Dsel}, 32'h1);

    // Edge source end to end
    wr(A_MASK, 32'h05);
    wr(A_EDGE, 32'h01);
    irq = 8'h01; tick(); irq = 8'h00;
    tick(2);
    rd("edge_pend_set", A_PEND, 32'h01);
    check("edge_intr_not_yet", {31'h0, bus.Intr}, 32'h0);
    tick();
    check("edge_intr_up", {31'h0, bus.Intr}, 32'h1);
    ack();
    check("edge_ivec", {27'h0, bus.Ivec}, 32'h0);
    check("edge_intr_down", {31'h0, bus.Intr}, 32'h0);
    rd("edge_stat_serv", A_STAT, 32'h20);
    rd("edge_pend_clr", A_PEND, 32'h00);
    wr(A_EOI, 32'h0);
    rd("edge_stat_eoi", A_STAT, 32'h00);
    tick();
    check("edge_idle_intr", {31'h0, bus.Intr}, 32'h0);

    // Priority between two level sources
    wr(A_EDGE, 32'h00);
    wr(A_MASK, 32'h24);
    irq = 8'h24; tick(4);
    check("prio_intr", {31'h0, bus.Intr}, 32'h1);
    ack();
    check("prio_ivec2", {27'h0, bus.Ivec}, 32'h2);
    rd("prio_stat", A_STAT, 32'h22);
    irq = 8'h20; tick(3);
    check("prio_no_nest", {31'h0, bus.Intr}, 32'h0);
    wr(A_EOI, 32'h0);
    tick();
    check("prio_intr_again", {31'h0, bus.Intr}, 32'h1);
    ack();
    check("prio_ivec5", {27'h0, bus.Ivec}, 32'h5);
    irq = 8'h00; tick(3);
    wr(A_EOI, 32'h0);
    rd("prio_stat_hold", A_STAT, 32'h05);

    // Masked edge source, then enabled by a MASK write
    wr(A_MASK, 32'h00);
    wr(A_EDGE, 32'h08);
    irq = 8'h08; tick(); irq = 8'h00;
    tick(4);
    rd("mask_pend", A_PEND, 32'h08);
    check("mask_intr_off", {31'h0, bus.Intr}, 32'h0);
    wr(A_MASK, 32'h08);
    check("mask_intr_at_write", {31'h0, bus.Intr}, 32'h0);
    tick();
    check("mask_intr_on", {31'h0, bus.Intr}, 32'h1);
    ack();
    check("mask_ivec", {27'h0, bus.Ivec}, 32'h3);
    rd("mask_stat", A_STAT, 32'h23);

    // Reset in the middle of service
    clr = 1'b1;
    #1;
    check("clr_serv_intr", {31'h0, bus.Intr}, 32'h0);
    check("clr_serv_ivec", {27'h0, bus.Ivec}, 32'h0);
    rd("clr_pend", A_PEND, 32'h0);
    rd("clr_mask", A_MASK, 32'h0);
    rd("clr_edge", A_EDGE, 32'h0);
    rd("clr_stat", A_STAT, 32'h0);
    tick(2);
    clr = 1'b0;

    // Level request withdrawn before Inta
    wr(A_MASK, 32'h02);
    irq = 8'h02; tick(3);
    check("wd_intr_up", {31'h0, bus.Intr}, 32'h1);
    irq = 8'h00;
    tick(2);
    check("wd_intr_still", {31'h0, bus.Intr}, 32'h1);
    tick();
    check("wd_intr_down", {31'h0, bus.Intr}, 32'h0);
    ack();
    rd("wd_stat", A_STAT, 32'h0);
    check("wd_intr_after_ack", {31'h0, bus.Intr}, 32'h0);

    // Set/clear collision on an edge source, plus reserved registers
    wr(A_EDGE, 32'h10);
    irq = 8'h10; tick(); irq = 8'h00;
    tick(3);
    rd("col_pend_first", A_PEND, 32'h10);
    irq = 8'h10; tick(); irq = 8'h00;
    tick();
    wr(A_PEND, 32'h10);
    rd("col_set_wins", A_PEND, 32'h10);
    wr(A_PEND, 32'h10);
    rd("col_w1c", A_PEND, 32'h00);
    wr(A_RSV2, 32'hFFFF_FFFF);
    rd("rsv_read", A_RSV2, 32'h0);
    rd("rsv_mask_untouched", A_MASK, 32'h02);

    // Reset while requesting drops Intr without a clock edge
    wr(A_EDGE, 32'h00);
    wr(A_MASK, 32'h01);
    irq = 8'h01; tick(3);
    check("clr_req_intr_up", {31'h0, bus.Intr}, 32'h1);
    #2 clr = 1'b1;
    #1 check("clr_req_intr_async", {31'h0, bus.Intr}, 32'h0);
    irq = 8'h00;
    tick(2);
    clr = 1'b0;
    tick(2);

    running = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
